// File: rtl/puf_eval_controller_if.sv
// Host-side challenge/response link of the PUF evaluation controller.
// master: host that offers challenges and consumes responses.
// slave:  the controller.
interface puf_eval_controller_if;
  logic       chal_valid;
  logic [7:0] chal_data;
  logic       chal_ready;
  logic       resp_valid;
  logic [7:0] resp_data;
  logic       resp_err;
  logic       resp_ready;

  modport master (
    output chal_valid, chal_data, resp_ready,
    input  chal_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  chal_valid, chal_data, resp_ready,
    output chal_ready, resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/puf_eval_controller.sv
// Sequencer for one PUF challenge/response evaluation at a time.
// Latches a challenge, pulses the buffer/arbiter reset, releases the race, waits for
// eight response bits (with a stall watchdog) and presents the captured byte to the host.
// Optional feature macro PUF_MAJORITY_VOTE_EN: three evaluations per challenge and a
// bitwise majority of the three captured bytes as the response.
module puf_eval_controller #(
  parameter int unsigned TIMEOUT_CYCLES   = 4096,
  parameter int unsigned ACK_PULSE_CYCLES = 2
) (
  input  logic                        clock,
  input  logic                        reset_n,
  puf_eval_controller_if.slave        host,
  output logic [7:0]                  puf_challenge,
  output logic                        puf_start,
  output logic                        buf_ack_reset,
  input  logic [3:0]                  buf_count,
  input  logic                        buf_ready_to_read,
  input  logic [7:0]                  buf_data,
  output logic                        busy
);

  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES);
  localparam logic [WdW-1:0] WdMax = WdW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] PulseLast = 4'(ACK_PULSE_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StClear, StWait, StCapture, StPresent} state_e;

  state_e         state_q, state_d;
  logic [3:0]     pulse_q, pulse_d;
  logic [WdW-1:0] wd_q, wd_d, wd_inc;
  logic [3:0]     prev_count_q;
  logic [7:0]     chal_q, chal_d;
  logic [7:0]     resp_data_q, resp_data_d;
  logic           resp_err_q, resp_err_d;
  logic           ack_q, start_q, valid_q;
  logic           progress;
`ifdef PUF_MAJORITY_VOTE_EN
  logic [1:0]     idx_q, idx_d;
  logic [7:0]     s0_q, s0_d, s1_q, s1_d;
`endif

  assign progress = (buf_count != prev_count_q);
  assign wd_inc   = wd_q + WdW'(1);

  // Next-state and datapath decode.
  always_comb begin
    state_d     = state_q;
    pulse_d     = pulse_q;
    wd_d        = wd_q;
    chal_d      = chal_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
`ifdef PUF_MAJORITY_VOTE_EN
    idx_d       = idx_q;
    s0_d        = s0_q;
    s1_d        = s1_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (host.chal_valid) begin
          chal_d  = host.chal_data;
          pulse_d = '0;
`ifdef PUF_MAJORITY_VOTE_EN
          idx_d   = '0;
`endif
          state_d = StClear;
        end
      end
      StClear: begin
        // Watchdog is held cleared so WAIT always starts from zero.
        wd_d = '0;
        if (pulse_q == PulseLast) state_d = StWait;
        else                      pulse_d = pulse_q + 4'd1;
      end
      StWait: begin
        if (buf_ready_to_read) begin
          state_d = StCapture;
        end else if (progress) begin
          wd_d = '0;
        end else if (wd_inc == WdMax) begin
          resp_err_d  = 1'b1;
          resp_data_d = 8'h00;
          state_d     = StPresent;
        end else begin
          wd_d = wd_inc;
        end
      end
      StCapture: begin
`ifdef PUF_MAJORITY_VOTE_EN
        if (idx_q == 2'd2) begin
          resp_data_d = (s0_q & s1_q) | (s0_q & buf_data) | (s1_q & buf_data);
          resp_err_d  = 1'b0;
          state_d     = StPresent;
        end else begin
          if (idx_q == 2'd0) s0_d = buf_data;
          else               s1_d = buf_data;
          idx_d   = idx_q + 2'd1;
          pulse_d = '0;
          state_d = StClear;
        end
`else
        resp_data_d = buf_data;
        resp_err_d  = 1'b0;
        state_d     = StPresent;
`endif
      end
      StPresent: begin
        if (host.resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // Datapath registers and registered outputs; the ack reset is held high during reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pulse_q      <= '0;
      wd_q         <= '0;
      prev_count_q <= '0;
      chal_q       <= '0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      ack_q        <= 1'b1;
      start_q      <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      pulse_q      <= pulse_d;
      wd_q         <= wd_d;
      prev_count_q <= buf_count;
      chal_q       <= chal_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      ack_q        <= (state_d == StClear);
      start_q      <= (state_d == StWait);
      valid_q      <= (state_d == StPresent);
    end
  end

`ifdef PUF_MAJORITY_VOTE_EN
  // Evaluation index and the first two captured samples.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idx_q <= '0;
      s0_q  <= '0;
      s1_q  <= '0;
    end else begin
      idx_q <= idx_d;
      s0_q  <= s0_d;
      s1_q  <= s1_d;
    end
  end
`endif

  assign puf_challenge   = chal_q;
  assign puf_start       = start_q;
  assign buf_ack_reset   = ack_q;
  assign host.resp_valid = valid_q;
  assign host.resp_data  = resp_data_q;
  assign host.resp_err   = resp_err_q;
  assign host.chal_ready = (state_q == StIdle);
  assign busy            = (state_q != StIdle);

endmodule

// File: tb/tb_puf_eval_controller.sv
// Self-checking bench for puf_eval_controller with a behavioural serial response buffer
// and a response scoreboard.
module tb_puf_eval_controller;

`ifdef PUF_MAJORITY_VOTE_EN
  localparam int Evals = 3;
`else
  localparam int Evals = 1;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       err;
  } resp_t;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] puf_challenge;
  logic       puf_start;
  logic       buf_ack_reset;
  logic       buf_ready_to_read;
  logic       busy;

  // Buffer model state.
  logic [3:0] m_cnt;
  logic [7:0] m_data;
  logic [3:0] m_limit;
  logic [7:0] cur_target;
  logic       force_ready;

  int         n_checks = 0;
  int         n_errors = 0;
  int         n_ack = 0;
  resp_t      sb_q[$];
  logic [7:0] tgt_q[$];

  puf_eval_controller_if host_if ();

  puf_eval_controller #(
    .TIMEOUT_CYCLES  (16),
    .ACK_PULSE_CYCLES(2)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .host             (host_if),
    .puf_challenge    (puf_challenge),
    .puf_start        (puf_start),
    .buf_ack_reset    (buf_ack_reset),
    .buf_count        (m_cnt),
    .buf_ready_to_read(buf_ready_to_read),
    .buf_data         (m_data),
    .busy             (busy)
  );

  always #5 clock = ~clock;

  // Serial buffer: one bit per cycle while the race is enabled, up to m_limit bits.
  always @(posedge clock or posedge buf_ack_reset) begin
    if (buf_ack_reset) begin
      m_cnt  <= 4'd0;
      m_data <= 8'h00;
    end else if (puf_start && m_cnt < m_limit) begin
      m_data <= {m_data[6:0], cur_target[7 - m_cnt]};
      m_cnt  <= m_cnt + 4'd1;
    end
  end

  assign buf_ready_to_read = (m_cnt == 4'd8) || force_ready;

  always @(posedge buf_ack_reset) n_ack++;

  // Each completed ack pulse starts a fresh evaluation with the next queued byte.
  always @(negedge buf_ack_reset) begin
    if (tgt_q.size() > 0) cur_target = tgt_q.pop_front();
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: compare each response at its handshake.
  always @(negedge clock) begin
    resp_t exp;
    #1;
    if (reset_n && host_if.resp_valid && host_if.resp_ready) begin
      if (sb_q.size() == 0) begin
        check_eq("resp_unexpected", 32'd1, 32'd0);
      end else begin
        exp = sb_q.pop_front();
        check_eq("resp_data", {24'd0, host_if.resp_data}, {24'd0, exp.data});
        check_eq("resp_err", {31'd0, host_if.resp_err}, {31'd0, exp.err});
      end
    end
  end

  task automatic send_chal(input logic [7:0] c);
    bit ok;
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clock);
      if (host_if.chal_ready) ok = 1;
    end
    if (!ok) check_eq("chal_ready_wait", 32'd0, 32'd1);
    host_if.chal_valid = 1'b1;
    host_if.chal_data  = c;
    @(negedge clock);
    host_if.chal_valid = 1'b0;
  endtask

  // Waits for resp_valid; lat = negedges from the last buf_count change to resp_valid.
  task automatic wait_resp(output int lat);
    int         last;
    logic [3:0] prev;
    bit         got;
    last = 0;
    prev = m_cnt;
    got  = 0;
    lat  = -1;
    for (int i = 1; i <= 300 && !got; i++) begin
      @(negedge clock);
      if (m_cnt != prev) begin
        last = i;
        prev = m_cnt;
      end
      if (host_if.resp_valid) begin
        got = 1;
        lat = i - last;
      end
    end
    if (!got) check_eq("resp_valid_wait", 32'd0, 32'd1);
  endtask

  initial begin
    int lat;
    int acks0;
    bit seen;
    host_if.chal_valid = 1'b0;
    host_if.chal_data  = 8'h00;
    host_if.resp_ready = 1'b1;
    m_limit     = 4'd8;
    force_ready = 1'b0;
    cur_target  = 8'h00;
    reset_n     = 1'b1;
    #1 reset_n  = 1'b0;

    // Reset values.
    repeat (5) @(negedge clock);
    check_eq("rst_ack", {31'd0, buf_ack_reset}, 32'd1);
    check_eq("rst_chal_ready", {31'd0, host_if.chal_ready}, 32'd1);
    check_eq("rst_start", {31'd0, puf_start}, 32'd0);
    check_eq("rst_valid", {31'd0, host_if.resp_valid}, 32'd0);
    check_eq("rst_data", {24'd0, host_if.resp_data}, 32'd0);
    check_eq("rst_err", {31'd0, host_if.resp_err}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_chal", {24'd0, puf_challenge}, 32'd0);
    reset_n = 1'b1;
    @(posedge clock);
    #1 check_eq("rst_release_ack", {31'd0, buf_ack_reset}, 32'd0);

    // Nominal evaluation.
    @(negedge clock);
    tgt_q.push_back(8'h3C);
    sb_q.push_back('{data: 8'h3C, err: 1'b0});
    acks0 = n_ack;
    send_chal(8'hA5);
    check_eq("nom_chal", {24'd0, puf_challenge}, 32'hA5);
    check_eq("nom_ack1", {31'd0, buf_ack_reset}, 32'd1);
    check_eq("nom_start_clear", {31'd0, puf_start}, 32'd0);
    check_eq("nom_busy", {31'd0, busy}, 32'd1);
    check_eq("nom_chal_ready", {31'd0, host_if.chal_ready}, 32'd0);
    @(negedge clock);
    check_eq("nom_ack2", {31'd0, buf_ack_reset}, 32'd1);
    check_eq("nom_start_clear2", {31'd0, puf_start}, 32'd0);
    @(negedge clock);
    check_eq("nom_ack_end", {31'd0, buf_ack_reset}, 32'd0);
    check_eq("nom_start_rise", {31'd0, puf_start}, 32'd1);
    wait_resp(lat);
    check_eq("nom_resp_lat", lat, 32'd2);
    check_eq("nom_start_present", {31'd0, puf_start}, 32'd0);
    check_eq("nom_ack_pulses", n_ack - acks0, Evals);
    @(negedge clock);
    check_eq("nom_idle_after", {31'd0, busy}, 32'd0);

    // Backpressure with ignored challenges.
    host_if.resp_ready = 1'b0;
    tgt_q.push_back(8'hC3);
    sb_q.push_back('{data: 8'hC3, err: 1'b0});
    send_chal(8'h5A);
    wait_resp(lat);
    for (int i = 0; i < 20; i++) begin
      check_eq("bp_valid", {31'd0, host_if.resp_valid}, 32'd1);
      check_eq("bp_data", {24'd0, host_if.resp_data}, 32'hC3);
      host_if.chal_valid = (i % 2 == 0);
      host_if.chal_data  = 8'hFF;
      @(negedge clock);
    end
    host_if.chal_valid = 1'b0;
    check_eq("bp_chal_hold", {24'd0, puf_challenge}, 32'h5A);
    check_eq("bp_busy", {31'd0, busy}, 32'd1);
    host_if.resp_ready = 1'b1;
    @(negedge clock);
    check_eq("bp_idle", {31'd0, host_if.chal_ready}, 32'd1);
    check_eq("bp_valid_drop", {31'd0, host_if.resp_valid}, 32'd0);

    // Timeout: buffer stalls at 3 bits.
    m_limit = 4'd3;
    tgt_q.push_back(8'hAA);
    sb_q.push_back('{data: 8'h00, err: 1'b1});
    send_chal(8'h33);
    wait_resp(lat);
    check_eq("to_lat", lat, 32'd16);
    check_eq("to_start_present", {31'd0, puf_start}, 32'd0);
    check_eq("to_err", {31'd0, host_if.resp_err}, 32'd1);
    @(negedge clock);
    m_limit = 4'd8;

`ifndef PUF_MAJORITY_VOTE_EN
    // ready_to_read arrives on the timeout cycle: capture wins.
    begin
      int         last;
      logic [3:0] prev;
      bit         got;
      m_limit = 4'd7;
      tgt_q.push_back(8'hFF);
      sb_q.push_back('{data: 8'h7F, err: 1'b0});
      send_chal(8'h3C);
      last = 0;
      prev = m_cnt;
      got  = 0;
      lat  = -1;
      for (int i = 1; i <= 300 && !got; i++) begin
        @(negedge clock);
        if (m_cnt != prev) begin
          last = i;
          prev = m_cnt;
        end
        if (host_if.resp_valid) begin
          got = 1;
          lat = i - last;
        end else if (m_cnt == 4'd7 && i - last == 15) begin
          force_ready = 1'b1;
        end
      end
      check_eq("simul_lat", lat, 32'd17);
      check_eq("simul_err", {31'd0, host_if.resp_err}, 32'd0);
      @(negedge clock);
      force_ready = 1'b0;
      m_limit     = 4'd8;
    end
`endif

    // Reset pulsed during WAIT discards the evaluation.
    tgt_q.push_back(8'h55);
    send_chal(8'h11);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      if (puf_start) seen = 1;
    end
    check_eq("rw_wait_reached", {31'd0, seen}, 32'd1);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check_eq("rw_busy", {31'd0, busy}, 32'd0);
    check_eq("rw_chal_ready", {31'd0, host_if.chal_ready}, 32'd1);
    check_eq("rw_start", {31'd0, puf_start}, 32'd0);
    check_eq("rw_ack", {31'd0, buf_ack_reset}, 32'd1);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge clock);
      if (host_if.resp_valid) seen = 1;
    end
    check_eq("rw_no_resp", {31'd0, seen}, 32'd0);

`ifdef PUF_MAJORITY_VOTE_EN
    // Majority of three evaluations.
    tgt_q.push_back(8'hF0);
    tgt_q.push_back(8'hF1);
    tgt_q.push_back(8'h70);
    sb_q.push_back('{data: 8'hF0, err: 1'b0});
    acks0 = n_ack;
    send_chal(8'hC5);
    wait_resp(lat);
    check_eq("mv_lat", lat, 32'd2);
    check_eq("mv_ack_pulses", n_ack - acks0, 32'd3);
    check_eq("mv_data", {24'd0, host_if.resp_data}, 32'hF0);
    @(negedge clock);
`endif

    repeat (3) @(negedge clock);
    check_eq("sb_drained", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/puf_eval_controller.md
# puf_eval_controller

Sequencer that runs one PUF challenge/response evaluation at a time on the serial PUF datapath. It accepts an 8-bit challenge from the host link and drives it to the scrambler. It then resets the response buffer and arbiter, releases the race, and waits for the buffer to collect 8 response bits. Finally it hands the captured byte back to the host, with a watchdog that aborts evaluations that stall.

## Interface
Parameters:
- TIMEOUT_CYCLES, 4096: max clock cycles without buffer progress before abort; must be ≥ 16.
- ACK_PULSE_CYCLES, 2: length in cycles of the buffer/arbiter reset pulse; 1..15.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- chal_valid  in  1  host offers a challenge.
- chal_data  in  8  challenge byte.
- chal_ready  out  1  controller accepts a challenge this cycle.
- puf_challenge  out  8  registered challenge held to the scrambler.
- puf_start  out  1  race enable; high only while waiting for response bits.
- buf_ack_reset  out  1  drives the buffer's active-high async reset (computer_ack_reset).
- buf_count  in  4  buffer bit count (0..8).
- buf_ready_to_read  in  1  buffer holds 8 bits.
- buf_data  in  8  buffer response byte.
- resp_valid  out  1  response available.
- resp_data  out  8  response byte.
- resp_err  out  1  qualifies resp_data; 1 = evaluation timed out.
- resp_ready  in  1  host consumes the response.
- busy  out  1  state ≠ IDLE.

## Operation
States: IDLE, CLEAR, WAIT, CAPTURE, PRESENT.
- IDLE: chal_ready=1.
  - On chal_valid, latch chal_data into puf_challenge, clear the evaluation index, and go to CLEAR.
- CLEAR: buf_ack_reset=1 for exactly ACK_PULSE_CYCLES cycles. puf_start=0. Then go to WAIT.
- WAIT: puf_start=1.
  - A watchdog counter of width clog2(TIMEOUT_CYCLES) clears on entry and whenever buf_count differs from its value in the previous cycle. Otherwise it increments.
  - If buf_ready_to_read=1, go to CAPTURE. This has priority over timeout in the same cycle.
  - Else, if the counter reaches TIMEOUT_CYCLES-1, set resp_err=1, resp_data=8'h00, and go to PRESENT.
- CAPTURE: puf_start=0. Register buf_data, then go to PRESENT (or back to CLEAR, see Configuration).
- PRESENT: resp_valid=1. resp_data and resp_err are stable until the handshake.
  - When resp_valid&resp_ready, go to IDLE.
  - A new challenge is not accepted in the same cycle.
- puf_challenge changes only on IDLE acceptance.
- chal_valid outside IDLE is ignored; the host must hold it until chal_ready.
- buf_count values above 8 count as progress but have no other effect.

Reset (reset_n low, asynchronous):
- State goes to IDLE. Watchdog and index are cleared.
- puf_challenge=0, puf_start=0, resp_valid=0, resp_data=0, resp_err=0, busy=0, chal_ready=1 (combinational from IDLE).
- buf_ack_reset=1 for as long as reset_n is low, so the buffer and arbiter are held in reset. It drops on the first clock edge after release.
- Reset mid-evaluation discards all progress; no response is presented.

## Timing
- Challenge accepted at edge N: buf_ack_reset is high for cycles N+1..N+ACK_PULSE_CYCLES, and puf_start rises at cycle N+ACK_PULSE_CYCLES+1.
- buf_ready_to_read sampled high at edge M: CAPTURE occupies cycle M+1, and resp_valid is high from cycle M+2.
- Timeout detected at edge M: resp_valid is high from cycle M+1.
- All outputs are registered except chal_ready and busy, which decode the state.
- Minimum accept-to-accept period at resp_ready=1: ACK_PULSE_CYCLES + 8-bit collection time + 3 cycles.

## Configuration
- Macro: PUF_MAJORITY_VOTE_EN.
- Undefined: one evaluation per challenge, as described above.
- Defined: three evaluations per challenge.
  - CAPTURE stores buf_data into sample register 0/1/2 by index.
  - After samples 0 and 1, CAPTURE returns to CLEAR: index increments and a full reset pulse occurs before the next race.
  - After sample 2, resp_data = bitwise majority of the three samples.
  - A timeout in any evaluation aborts the remaining ones and presents resp_err=1, resp_data=8'h00.
  - Latency from the third capture to resp_valid is unchanged.

## Test plan
- Reset: hold reset_n low 5 cycles → buf_ack_reset=1, chal_ready=1, all other outputs 0. Release → buf_ack_reset=0 at the next edge.
- Nominal: challenge 8'hA5, buffer model returns 8 bits forming 8'h3C → puf_challenge=8'hA5, 2-cycle ack pulse, resp_data=8'h3C, resp_err=0, resp_valid 2 cycles after ready_to_read.
- Backpressure: hold resp_ready=0 for 20 cycles → resp_valid and resp_data stay stable; chal_valid pulses during this time are ignored; IDLE follows the handshake.
- Timeout: TIMEOUT_CYCLES=16, buffer stalls at buf_count=3 → resp_err=1 and resp_data=8'h00 exactly 16 cycles after the last count change; puf_start=0 during PRESENT.
- Simultaneous events: ready_to_read rises on the timeout cycle → normal capture, resp_err=0. Separately, reset_n pulsed low during WAIT → IDLE immediately and no resp_valid.
- PUF_MAJORITY_VOTE_EN: samples 8'hF0, 8'hF1, 8'h70 → three ack pulses, resp_data=8'hF0.
